bcd_xs3_seq_ctrl: RTL and testbench
===================================

// Module: bcd_xs3_seq_ctrl
// PURPOSE
//  Sequencer for the BCD-to-excess-3 datapath. Accepts one packed multi-digit BCD word.
//  Converts one 4-bit digit per clock through a single shared digit converter.
//  Returns the assembled excess-3 word to the consumer.
//  Sits between a BCD source (e.g. a counter or keypad front end) and display/arithmetic logic.
// PARAMETERS
//  NDIGITS  4  number of BCD digits per word (>=1); word width = 4*NDIGITS
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          source presents a BCD word
//  in_ready   out  1          block can accept a word (high only in IDLE)
//  in_bcd     in   4*NDIGITS  packed BCD, digit 0 = bits[3:0]
//  out_valid  out  1          out_xs3/out_err valid
//  out_ready  in   1          consumer accepts result
//  out_xs3    out  4*NDIGITS  packed excess-3 result, digit i = in digit i + 3 (mod 16)
//  out_err    out  1          1 if any input digit > 9
//  busy       out  1          high in CONV or DONE
// BEHAVIOUR
//  Reset: async assert of rst_n forces state=IDLE, idx=0, src=0, out_xs3=0, out_err=0.
//   Outputs during reset: out_valid=0, busy=0, in_ready=1. Applies from any state, including mid-CONV; partial results are discarded.
//  FSM states: IDLE, CONV, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_bcd into src, clear out_xs3 and out_err, set idx=0, go to CONV.
//   CONV: each edge writes xs3(src[idx]) into out_xs3[idx] and ORs (src[idx]>9) into out_err.
//    If idx==NDIGITS-1, go to DONE; otherwise idx++. in_ready=0, out_valid=0.
//   DONE: out_valid=1; out_xs3 and out_err are held stable.
//    On out_ready, go to IDLE; otherwise stay in DONE indefinitely (backpressure).
//  Latency: out_valid rises exactly NDIGITS cycles after the accepting edge.
//   Minimum throughput: one word per NDIGITS+2 cycles.
//  A DONE handshake and a new in_valid in the same cycle do not overlap.
//   in_ready is 0 in DONE, so the new word is accepted in the following IDLE cycle.
//  in_valid is ignored outside IDLE. in_bcd is sampled only on the accepting edge.
//  Changes to in_bcd during CONV have no effect.
//  Arithmetic: digit add is 4-bit modulo 16 with no carry between digits. Invalid digits still convert:
//   A->D, B->E, C->F, D->0, E->1, F->2.
//  idx width = max(1, $clog2(NDIGITS)). NDIGITS=1: CONV lasts one cycle.
//  out_valid, in_ready and busy decode from the state register only (no combinational path from inputs).
// STRUCTURE
//  Shared package bcd_pkg: XS3_OFFSET=4'd3, BCD_MAX=4'd9, state encodings (IDLE=2'd0, CONV=2'd1, DONE=2'd2).
//  Sub-module xs3_digit: combinational 4-bit in -> 4-bit out (+3) and 1-bit invalid flag (>9).
//   Exactly one instance, shared across all digits via the idx mux.
//  Top level contains the FSM, idx counter, src register, result register and error accumulator.
// TESTING (NDIGITS=4)
//  1. in_bcd=16'h1234, out_ready=1 -> out_valid exactly 4 cycles after accept; out_xs3=16'h4567, out_err=0.
//  2. 16'h0000, then 16'h9999 back-to-back -> 16'h3333 then 16'hCCCC, out_err=0; second accept one cycle after first output handshake.
//  3. in_bcd=16'h12A4 -> out_xs3=16'h45D7, out_err=1; next word 16'h0001 -> 16'h3334, out_err=0 (error flag cleared).
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid stays 1 and out_xs3 is stable; in_ready=0 until one cycle after out_ready=1.
//  5. rst_n pulsed low 2 cycles into CONV -> out_valid=0 and in_ready=1 immediately; next word 16'h5678 -> 16'h89AB.
//  6. in_valid held high with in_bcd changing during CONV -> only the accepted word is converted; one result per handshake.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD-to-excess-3 sequencer.
package bcd_pkg;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD to excess-3 converter with an invalid-digit flag.
module xs3_digit
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] xs3_o,
   output logic       invalid_o
);

   // Modulo-16 add: invalid digits wrap (A->D ... F->2).
   assign xs3_o     = digit_i + XS3_OFFSET;
   assign invalid_o = (digit_i > BCD_MAX);

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequencer that converts a packed BCD word to excess-3, one digit per clock,
// through a single shared xs3_digit instance.
module bcd_xs3_seq_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] in_bcd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NDIGITS-1:0] out_xs3,
   output logic                 out_err,
   output logic                 busy
);

   localparam int unsigned W  = 4 * NDIGITS;
   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    src_q, src_d;
   logic [W-1:0]    xs3_q, xs3_d;
   logic            err_q, err_d;

   logic [3:0]      cur_digit;
   logic [3:0]      cur_xs3;
   logic            cur_invalid;

   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IW'(i)) cur_digit = src_q[4*i +: 4];
      end
   end

   xs3_digit u_xs3_digit (
      .digit_i   (cur_digit),
      .xs3_o     (cur_xs3),
      .invalid_o (cur_invalid)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src_d   = src_q;
      xs3_d   = xs3_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               src_d   = in_bcd;
               xs3_d   = '0;
               err_d   = 1'b0;
               idx_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            for (int i = 0; i < NDIGITS; i++) begin
               if (idx_q == IW'(i)) xs3_d[4*i +: 4] = cur_xs3;
            end
            err_d = err_q | cur_invalid;
            if (idx_q == IW'(NDIGITS - 1)) state_d = DONE;
            else                           idx_d   = idx_q + IW'(1);
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         src_q   <= '0;
         xs3_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         xs3_q   <= xs3_d;
         err_q   <= err_d;
      end
   end

   // Handshake flags decode from state only, so no input-to-output paths.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_xs3   = xs3_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Self-checking bench for bcd_xs3_seq_ctrl (NDIGITS=4) against a digit-arithmetic model.
module tb_bcd_xs3_seq_ctrl;

   localparam int unsigned ND = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_bcd = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_xs3;
   logic          out_err;
   logic          busy;

   int errors = 0;
   int checks = 0;

   bcd_xs3_seq_ctrl #(.NDIGITS(ND)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_xs3   (out_xs3),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_xs3(input logic [15:0] w);
      int r = 0;
      for (int i = 0; i < ND; i++) begin
         int d = (int'(w) >> (4 * i)) % 16;
         r += ((d + 3) % 16) << (4 * i);
      end
      return 16'(r);
   endfunction

   function automatic logic model_err(input logic [15:0] w);
      logic e = 1'b0;
      for (int i = 0; i < ND; i++) begin
         int d = (int'(w) >> (4 * i)) % 16;
         if (d > 9) e = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [15:0] rand_word();
      return 16'($urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents w and returns just after the accepting edge.
   task automatic do_accept(input logic [15:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_bcd   = w;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%0b ready=%0b busy=%0b required 0 1 0",
                  out_valid, in_ready, busy);
      end
      checks++;
      if (out_xs3 !== 16'h0000 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: xs3=%h err=%0b required 0000 0", out_xs3, out_err);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      do_accept(16'h1234);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy: busy=%0b ready=%0b required 1 0", busy, in_ready);
      end
      wait_valid(lat);
      checks++;
      if (lat != ND) begin
         errors++;
         $display("FAIL basic_latency: got %0d required %0d", lat, ND);
      end
      checks++;
      if (out_xs3 !== 16'h4567 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_data: xs3=%h err=%0b required 4567 0", out_xs3, out_err);
      end
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_return_idle: ready=%0b valid=%0b required 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      do_accept(16'h0000);
      wait_valid(lat);
      checks++;
      if (out_xs3 !== 16'h3333 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: xs3=%h err=%0b required 3333 0", out_xs3, out_err);
      end
      // New word offered during the DONE handshake cycle.
      in_valid = 1'b1;
      in_bcd   = 16'h9999;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ready_in_done: got %0b required 0", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: ready=%0b busy=%0b required 1 0", in_ready, busy);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_accept: busy=%0b required 1", busy);
      end
      wait_valid(lat);
      checks++;
      if (lat != ND || out_xs3 !== 16'hCCCC || out_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d xs3=%h err=%0b required %0d CCCC 0",
                  lat, out_xs3, out_err, ND);
      end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_error_clear();
      int lat;
      do_accept(16'h12A4);
      wait_valid(lat);
      checks++;
      if (out_xs3 !== 16'h45D7 || out_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: xs3=%h err=%0b required 45D7 1", out_xs3, out_err);
      end
      handshake();
      do_accept(16'h0001);
      wait_valid(lat);
      checks++;
      if (out_xs3 !== 16'h3334 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: xs3=%h err=%0b required 3334 0", out_xs3, out_err);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [15:0] w = 16'h8071;
      do_accept(w);
      wait_valid(lat);
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_xs3 !== model_xs3(w) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%0b xs3=%h ready=%0b required 1 %h 0",
                     c, out_valid, out_xs3, in_ready, model_xs3(w));
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready_same_cycle: got %0b required 0", in_ready);
      end
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: ready=%0b valid=%0b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_conv();
      int lat;
      do_accept(16'h1234);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
          out_xs3 !== 16'h0000 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%0b ready=%0b busy=%0b xs3=%h err=%0b required 0 1 0 0000 0",
                  out_valid, in_ready, busy, out_xs3, out_err);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      do_accept(16'h5678);
      wait_valid(lat);
      checks++;
      if (lat != ND || out_xs3 !== 16'h89AB || out_err !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: lat=%0d xs3=%h err=%0b required %0d 89AB 0",
                  lat, out_xs3, out_err, ND);
      end
      handshake();
   endtask

   task automatic test_hold_valid();
      int lat;
      logic [15:0] w;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         w      = rand_word();
         in_bcd = w;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready[%0d]: got %0b required 1", k, in_ready);
         end
         tick();
         lat = 0;
         while (!out_valid && lat < 50) begin
            in_bcd = rand_word();
            tick();
            lat++;
         end
         checks++;
         if (lat != ND || out_xs3 !== model_xs3(w) || out_err !== model_err(w)) begin
            errors++;
            $display("FAIL hold_data[%0d]: lat=%0d xs3=%h err=%0b required %0d %h %0b",
                     k, lat, out_xs3, out_err, ND, model_xs3(w), model_err(w));
         end
         handshake();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_result[%0d]: valid=%0b busy=%0b required 0 0",
                     k, out_valid, busy);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] w;
      for (int k = 0; k < 20; k++) begin
         w = rand_word();
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         do_accept(w);
         wait_valid(lat);
         for (int s = 0; s < int'($urandom_range(0, 3)); s++) tick();
         checks++;
         if (out_valid !== 1'b1 || out_xs3 !== model_xs3(w) || out_err !== model_err(w)) begin
            errors++;
            $display("FAIL rand[%0d] in=%h: valid=%0b xs3=%h err=%0b required 1 %h %0b",
                     k, w, out_valid, out_xs3, out_err, model_xs3(w), model_err(w));
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_error_clear();
      test_backpressure();
      test_reset_mid_conv();
      test_hold_valid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
